// File: rtl/pc_sequencer_if.sv
// Fetch-stage PC sequencer bus.
// Groups the control/ALU/memory inputs and the PC/RAS status outputs.
//   master: drives BUSYWAIT, MODE, RD_OFFSET, ZERO; observes PC and flags
//   slave : the sequencer itself
interface pc_sequencer_if #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned OFF_W = 8
);
  logic             BUSYWAIT;
  logic [2:0]       MODE;
  logic [OFF_W-1:0] RD_OFFSET;
  logic             ZERO;
  logic [PC_W-1:0]  PC;
  logic [PC_W-1:0]  PC_PLUS4;
  logic             REDIRECT;
  logic             RAS_EMPTY;
  logic             RAS_FULL;
  logic             RAS_ERR;

  modport master (
    output BUSYWAIT, MODE, RD_OFFSET, ZERO,
    input  PC, PC_PLUS4, REDIRECT, RAS_EMPTY, RAS_FULL, RAS_ERR
  );

  modport slave (
    input  BUSYWAIT, MODE, RD_OFFSET, ZERO,
    output PC, PC_PLUS4, REDIRECT, RAS_EMPTY, RAS_FULL, RAS_ERR
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC generator and PC register for the fetch stage, with a circular
// return-address stack for CALL/RET.
// Ports:
//   CLK    : rising-edge clock
//   RESETN : asynchronous active-low reset
//   bus    : pc_sequencer_if.slave
//            in : BUSYWAIT (stall), MODE, RD_OFFSET (signed words), ZERO
//            out: PC, PC_PLUS4 (combinational), REDIRECT, RAS_EMPTY,
//                 RAS_FULL, RAS_ERR (sticky)
module pc_sequencer #(
  parameter int unsigned    PC_W      = 32,
  parameter int unsigned    OFF_W     = 8,
  parameter int unsigned    RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic          CLK,
  input  logic          RESETN,
  pc_sequencer_if.slave bus
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [2:0] MODE_SEQ  = 3'd0;
  localparam logic [2:0] MODE_JUMP = 3'd1;
  localparam logic [2:0] MODE_BEQ  = 3'd2;
  localparam logic [2:0] MODE_BNE  = 3'd3;
  localparam logic [2:0] MODE_CALL = 3'd4;
  localparam logic [2:0] MODE_RET  = 3'd5;

  logic [PC_W-1:0]  r_pc;
  logic             r_redirect;
  logic [PC_W-1:0]  r_ras [RAS_DEPTH];
  logic [PTR_W-1:0] r_top;
  logic [CNT_W-1:0] r_cnt;
  logic             r_empty;
  logic             r_full;
  logic             r_err;

  logic [PC_W-1:0]  w_pc_plus4;
  logic [PC_W-1:0]  w_off_ext;
  logic [PC_W-1:0]  w_target;
  logic [PC_W-1:0]  w_next_pc;
  logic             w_redirect;
  logic             w_push;
  logic             w_pop;
  logic             w_err_set;
  logic [PTR_W-1:0] w_top_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Sign-extend the word offset, then scale to bytes; overflow wraps silently.
  assign w_pc_plus4 = r_pc + PC_W'(4);
  assign w_off_ext  = PC_W'($signed(bus.RD_OFFSET));
  assign w_target   = w_pc_plus4 + {w_off_ext[PC_W-3:0], 2'b00};

  // Next-PC selection and stack control
  always_comb begin
    w_next_pc  = w_pc_plus4;
    w_redirect = 1'b0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_err_set  = 1'b0;
    case (bus.MODE)
      MODE_JUMP: begin
        w_next_pc  = w_target;
        w_redirect = 1'b1;
      end
      MODE_BEQ: begin
        if (bus.ZERO) begin
          w_next_pc  = w_target;
          w_redirect = 1'b1;
        end
      end
      MODE_BNE: begin
        if (!bus.ZERO) begin
          w_next_pc  = w_target;
          w_redirect = 1'b1;
        end
      end
      MODE_CALL: begin
        w_next_pc  = w_target;
        w_redirect = 1'b1;
        w_push     = 1'b1;
        w_err_set  = r_full;
      end
      MODE_RET: begin
        if (!r_empty) begin
          w_next_pc  = r_ras[r_top];
          w_redirect = 1'b1;
          w_pop      = 1'b1;
        end else begin
          w_err_set  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Pointer/count update; a push when full overwrites the oldest slot,
  // which is exactly the slot after the current top.
  always_comb begin
    w_top_nxt = r_top;
    w_cnt_nxt = r_cnt;
    if (w_push) begin
      w_top_nxt = PTR_W'(r_top + 1'b1);
      if (!r_full) w_cnt_nxt = CNT_W'(r_cnt + 1'b1);
    end else if (w_pop) begin
      w_top_nxt = PTR_W'(r_top - 1'b1);
      w_cnt_nxt = CNT_W'(r_cnt - 1'b1);
    end
  end

  // Control state; stall freezes everything
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_pc       <= RESET_PC;
      r_redirect <= 1'b0;
      r_top      <= '0;
      r_cnt      <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_err      <= 1'b0;
    end else if (!bus.BUSYWAIT) begin
      r_pc       <= w_next_pc;
      r_redirect <= w_redirect;
      r_top      <= w_top_nxt;
      r_cnt      <= w_cnt_nxt;
      r_empty    <= (w_cnt_nxt == '0);
      r_full     <= (w_cnt_nxt == CNT_W'(RAS_DEPTH));
      r_err      <= r_err | w_err_set;
    end
  end

  // Stack storage carries no reset; entries are only read when counted valid
  always_ff @(posedge CLK) begin
    if (RESETN && !bus.BUSYWAIT && w_push) r_ras[w_top_nxt] <= w_pc_plus4;
  end

  assign bus.PC        = r_pc;
  assign bus.PC_PLUS4  = w_pc_plus4;
  assign bus.REDIRECT  = r_redirect;
  assign bus.RAS_EMPTY = r_empty;
  assign bus.RAS_FULL  = r_full;
  assign bus.RAS_ERR   = r_err;

endmodule
